// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between the WB stage (port 0) and a FIFO-buffered
// long-latency port (port 1). Optional macro STARVE_GUARD_EN adds a forced grant for a starved FIFO head.
module regfile_wb_arbiter #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_WAIT   = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in0_valid_i,
   output logic                            in0_ready_o,
   input  logic [4:0]                      in0_rd_i,
   input  logic [XLEN-1:0]                 in0_data_i,
   input  logic                            in1_valid_i,
   output logic                            in1_ready_o,
   input  logic [4:0]                      in1_rd_i,
   input  logic [XLEN-1:0]                 in1_data_i,
   output logic                            rf_wr_en_o,
   output logic [4:0]                      rf_rd_o,
   output logic [XLEN-1:0]                 rf_wdata_o,
   output logic [31:0]                     pend_mask_o,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [4:0]      ent_rd_q   [FIFO_DEPTH];
   logic [XLEN-1:0] ent_data_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] ent_vld_q, ent_vld_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic [31:0]      pend_mask_q, pend_mask_d;
   logic             rf_wr_en_q, rf_wr_en_d;
   logic [4:0]       rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;

   logic force_c, nonempty_c, push_c, pop_c, take0_c;

`ifdef STARVE_GUARD_EN
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              force_q, force_d;

   // Force is precomputed from next-state so the grant and in0_ready come straight from flops.
   always_comb begin
      wait_d  = '0;
      force_d = 1'b0;
      if (nonempty_c && !pop_c) wait_d = WAIT_W'(wait_q + WAIT_W'(1));
      force_d = (wait_d == WAIT_W'(MAX_WAIT)) && (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_q  <= '0;
         force_q <= 1'b0;
      end else begin
         wait_q  <= wait_d;
         force_q <= force_d;
      end
   end

   assign force_c = force_q;
`else
   assign force_c = 1'b0;
`endif

   assign nonempty_c = (count_q != '0);
   assign take0_c    = in0_valid_i && !force_c;
   assign pop_c      = force_c || (!in0_valid_i && nonempty_c);
   // x0 writes on port 1 are accepted but dropped before the FIFO.
   assign push_c     = in1_valid_i && !full_q && (in1_rd_i != 5'd0);

   always_comb begin
      logic [4:0] rd_nxt;
      ent_vld_d   = ent_vld_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      full_d      = full_q;
      pend_mask_d = '0;
      rf_wr_en_d  = 1'b0;
      rf_rd_d     = rf_rd_q;
      rf_wdata_d  = rf_wdata_q;
      rd_nxt      = '0;

      if (pop_c) begin
         ent_vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d            = PTR_W'(rd_ptr_q + PTR_W'(1));
         rf_wr_en_d          = 1'b1;
         rf_rd_d             = ent_rd_q[rd_ptr_q];
         rf_wdata_d          = ent_data_q[rd_ptr_q];
      end else if (take0_c && (in0_rd_i != 5'd0)) begin
         rf_wr_en_d = 1'b1;
         rf_rd_d    = in0_rd_i;
         rf_wdata_d = in0_data_i;
      end

      if (push_c) begin
         ent_vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d            = PTR_W'(wr_ptr_q + PTR_W'(1));
      end

      count_d = CNT_W'(count_q + CNT_W'(push_c) - CNT_W'(pop_c));
      full_d  = (count_d == CNT_W'(FIFO_DEPTH));

      for (int i = 0; i < FIFO_DEPTH; i++) begin
         rd_nxt = (push_c && (PTR_W'(i) == wr_ptr_q)) ? in1_rd_i : ent_rd_q[i];
         if (ent_vld_d[i]) pend_mask_d = pend_mask_d | (32'd1 << rd_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ent_vld_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         pend_mask_q <= '0;
         rf_wr_en_q  <= 1'b0;
         rf_rd_q     <= '0;
         rf_wdata_q  <= '0;
      end else begin
         ent_vld_q   <= ent_vld_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         pend_mask_q <= pend_mask_d;
         rf_wr_en_q  <= rf_wr_en_d;
         rf_rd_q     <= rf_rd_d;
         rf_wdata_q  <= rf_wdata_d;
      end
   end

   // Payload storage needs no reset; entry validity is tracked separately.
   always_ff @(posedge clk) begin
      if (push_c) begin
         ent_rd_q[wr_ptr_q]   <= in1_rd_i;
         ent_data_q[wr_ptr_q] <= in1_data_i;
      end
   end

   assign in0_ready_o  = !force_c;
   assign in1_ready_o  = !full_q;
   assign rf_wr_en_o   = rf_wr_en_q;
   assign rf_rd_o      = rf_rd_q;
   assign rf_wdata_o   = rf_wdata_q;
   assign pend_mask_o  = pend_mask_q;
   assign fifo_count_o = count_q;

endmodule
